// File: rtl/zbus_pkg.sv
// zbus_ports shared types: FSM state encoding and
// a constant-function clog2 for derived widths.
package zbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_END,
    ST_RD_HOLD
  } zbus_st_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/zbus_sync.sv
// 2-FF synchroniser, W bits, sync reset to all-ones.
// Ports: clk, rst, d (async in), q (synced out).
module zbus_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '1;
      q  <= '1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/zbus_ports.sv
// ZX-bus I/O port bank + 16 KB memory window decode.
// Ports: Z80 bus (za/zd/strobes), port bank strobes
// and data, window config, per-window chip selects.
module zbus_ports
  import zbus_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hAB,
  parameter int NPORTS = 4,
  parameter int NWIN = 2,
  localparam int AW = clog2(NPORTS)
) (
  input  logic                fclk,
  input  logic                rst,
  input  logic [15:0]         za,
  inout  wire  [7:0]          zd,
  input  logic                ziorq_n,
  input  logic                zrd_n,
  input  logic                zwr_n,
  input  logic                zmreq_n,
  input  logic                zcsrom_n,
  output wire                 ziorqge,
  output wire                 zblkrom,
  output logic [AW-1:0]       ports_addr,
  output logic [7:0]          ports_wrdata,
  output logic                ports_wrstb,
  output logic                ports_rdstb,
  input  logic [NPORTS*8-1:0] ports_rddata,
  input  logic [NWIN*2-1:0]   rommap_win,
  input  logic [NWIN-1:0]     rommap_ena,
  output logic [NWIN-1:0]     mem_cs_n
);

  zbus_st_t    st;
  zbus_st_t    nxt;
  logic [2:0]  sq;
  logic        iorq_s;
  logic        rd_s_n;
  logic        wr_s_n;
  logic [AW-1:0] idx;
  logic        hit;
  logic        wr_s;
  logic        rd_s;
  logic        end_c;
  logic        wr_go;
  logic        rd_go;
  logic        rd_end;
  logic [7:0]  rdhold;
  logic        blk;
  wire         unused_za = ^za[13:8+AW];

  zbus_sync #(.W(3)) u_sync (
    .clk (fclk),
    .rst (rst),
    .d   ({ziorq_n, zrd_n, zwr_n}),
    .q   (sq)
  );

  assign iorq_s = sq[2];
  assign rd_s_n = sq[1];
  assign wr_s_n = sq[0];

  assign idx = za[8 +: AW];
  assign hit = (za[7:0] == BASE_ADDR) && za[15] &&
               (32'(idx) < NPORTS);

  assign wr_s  = !iorq_s && !wr_s_n && hit;
  assign rd_s  = !iorq_s && !rd_s_n && hit;
  // Cycle over once iorq drops, or both data strobes
  // have gone away.
  assign end_c = iorq_s || (rd_s_n && wr_s_n);

  always_comb begin
    nxt    = st;
    wr_go  = 1'b0;
    rd_go  = 1'b0;
    rd_end = 1'b0;
    unique case (st)
      ST_IDLE: begin
        if (wr_s) begin
          wr_go = 1'b1;
          nxt   = ST_WR_END;
        end else if (rd_s) begin
          rd_go = 1'b1;
          nxt   = ST_RD_HOLD;
        end
      end
      ST_WR_END: begin
        if (end_c) nxt = ST_IDLE;
      end
      ST_RD_HOLD: begin
        if (end_c) begin
          rd_end = 1'b1;
          nxt    = ST_IDLE;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      st           <= ST_IDLE;
      ports_wrstb  <= 1'b0;
      ports_rdstb  <= 1'b0;
      ports_addr   <= '0;
      ports_wrdata <= '0;
      rdhold       <= '0;
    end else begin
      st          <= nxt;
      ports_wrstb <= wr_go;
      ports_rdstb <= rd_end;
      if (wr_go || rd_go) ports_addr <= idx;
      if (wr_go) ports_wrdata <= zd;
      if (rd_go) rdhold <= ports_rddata[{idx, 3'b000} +: 8];
    end
  end

  // Release follows the raw strobe so the bus frees
  // without waiting for the synchroniser.
  assign zd = (st == ST_RD_HOLD && !ziorq_n &&
               !zrd_n && hit) ? rdhold : 8'hzz;

  assign ziorqge = hit ? 1'b1 : 1'bz;

  always_comb begin
    blk      = 1'b0;
    mem_cs_n = '1;
    for (int i = 0; i < NWIN; i++) begin
      if (rommap_ena[i] &&
          za[15:14] == rommap_win[2*i +: 2]) begin
        blk = 1'b1;
        if (!zmreq_n && (!zwr_n || (!zrd_n && !zcsrom_n)))
          mem_cs_n[i] = 1'b0;
      end
    end
  end

  assign zblkrom = blk ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_zbus_ports.sv
// Bench for zbus_ports: window table, directed I/O
// sequences and randomized port traffic vs a model.
module tb_zbus_ports;

  logic        fclk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] za = '0;
  wire  [7:0]  zd;
  logic        ziorq_n = 1'b1;
  logic        zrd_n = 1'b1;
  logic        zwr_n = 1'b1;
  logic        zmreq_n = 1'b1;
  logic        zcsrom_n = 1'b1;
  wire         ziorqge;
  wire         zblkrom;
  logic [1:0]  ports_addr;
  logic [7:0]  ports_wrdata;
  logic        ports_wrstb;
  logic        ports_rdstb;
  logic [31:0] ports_rddata = '0;
  logic [3:0]  rommap_win = '0;
  logic [1:0]  rommap_ena = '0;
  logic [1:0]  mem_cs_n;

  logic        tb_oe = 1'b0;
  logic [7:0]  tb_d = '0;
  assign zd = tb_oe ? tb_d : 8'hzz;

  // Undriven bus reads as FF; undriven flags read 0.
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (zd[i]);
  end
  pulldown (ziorqge);
  pulldown (zblkrom);

  zbus_ports dut (
    .fclk         (fclk),
    .rst          (rst),
    .za           (za),
    .zd           (zd),
    .ziorq_n      (ziorq_n),
    .zrd_n        (zrd_n),
    .zwr_n        (zwr_n),
    .zmreq_n      (zmreq_n),
    .zcsrom_n     (zcsrom_n),
    .ziorqge      (ziorqge),
    .zblkrom      (zblkrom),
    .ports_addr   (ports_addr),
    .ports_wrdata (ports_wrdata),
    .ports_wrstb  (ports_wrstb),
    .ports_rdstb  (ports_rdstb),
    .ports_rddata (ports_rddata),
    .rommap_win   (rommap_win),
    .rommap_ena   (rommap_ena),
    .mem_cs_n     (mem_cs_n)
  );

  always #5 fclk = ~fclk;

  int cyc = 0;
  always @(posedge fclk) cyc <= cyc + 1;

  int wr_cnt = 0;
  int rd_cnt = 0;
  int wr_at = 0;
  int rd_at = 0;
  always @(negedge fclk) begin
    if (ports_wrstb) begin
      wr_cnt++;
      wr_at = cyc;
    end
    if (ports_rdstb) begin
      rd_cnt++;
      rd_at = cyc;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  int t0;
  int t1;
  logic [7:0] zd_early;
  logic [7:0] zd_end;
  logic [7:0] zd_rel;
  logic       ge_end;

  task automatic io_cyc(input bit w, input bit r,
                        input bit drv,
                        input logic [15:0] a,
                        input logic [7:0] d,
                        input int hold);
    wr_cnt = 0;
    rd_cnt = 0;
    @(negedge fclk);
    za = a;
    tb_d = d;
    tb_oe = drv;
    ziorq_n = 1'b0;
    zwr_n = !w;
    zrd_n = !r;
    t0 = cyc;
    repeat (2) @(negedge fclk);
    zd_early = zd;
    repeat (hold - 2) @(negedge fclk);
    zd_end = zd;
    ge_end = ziorqge;
    ziorq_n = 1'b1;
    zwr_n = 1'b1;
    zrd_n = 1'b1;
    t1 = cyc;
    #1;
    zd_rel = zd;
    tb_oe = 1'b0;
    repeat (5) @(negedge fclk);
  endtask

  typedef struct {
    logic [15:0] a;
    logic        mreq_n;
    logic        rd_n;
    logic        wr_n;
    logic        csrom_n;
    logic [3:0]  win;
    logic [1:0]  ena;
    logic [1:0]  cs;
    logic        blk;
  } mvec_t;

  mvec_t mt[8];

  logic [1:0]  m_addr;
  logic [7:0]  m_wrdata;

  initial begin
    mt[0] = '{16'hC000, 0, 0, 1, 0, 4'b1100, 2'b10, 2'b01, 1};
    mt[1] = '{16'hC000, 0, 0, 1, 1, 4'b1100, 2'b10, 2'b11, 1};
    mt[2] = '{16'hC123, 0, 1, 0, 1, 4'b1100, 2'b10, 2'b01, 1};
    mt[3] = '{16'hC000, 1, 0, 1, 0, 4'b1100, 2'b10, 2'b11, 1};
    mt[4] = '{16'h0000, 0, 0, 1, 0, 4'b1100, 2'b11, 2'b10, 1};
    mt[5] = '{16'h4000, 0, 1, 0, 1, 4'b0101, 2'b11, 2'b00, 1};
    mt[6] = '{16'h4000, 0, 1, 0, 1, 4'b0101, 2'b00, 2'b11, 0};
    mt[7] = '{16'h4000, 0, 1, 0, 1, 4'b0110, 2'b01, 2'b11, 0};

    repeat (3) @(negedge fclk);
    chk("rst_wrstb", 32'(ports_wrstb), 0);
    chk("rst_rdstb", 32'(ports_rdstb), 0);
    chk("rst_addr", 32'(ports_addr), 0);
    chk("rst_wrdata", 32'(ports_wrdata), 0);
    chk("rst_zd", 32'(zd), 32'hFF);
    chk("rst_ge", 32'(ziorqge), 0);
    rst = 1'b0;
    repeat (2) @(negedge fclk);

    for (int i = 0; i < 8; i++) begin
      za = mt[i].a;
      zmreq_n = mt[i].mreq_n;
      zrd_n = mt[i].rd_n;
      zwr_n = mt[i].wr_n;
      zcsrom_n = mt[i].csrom_n;
      rommap_win = mt[i].win;
      rommap_ena = mt[i].ena;
      #1;
      chk($sformatf("tab_cs%0d", i), 32'(mem_cs_n), 32'(mt[i].cs));
      chk($sformatf("tab_blk%0d", i), 32'(zblkrom), 32'(mt[i].blk));
      @(negedge fclk);
    end

    for (int i = 0; i < 30; i++) begin
      int bank;
      bit acc;
      logic [1:0] ecs;
      logic eblk;
      za = 16'($urandom);
      zmreq_n = 1'($urandom);
      zrd_n = 1'($urandom);
      zwr_n = 1'($urandom);
      zcsrom_n = 1'($urandom);
      rommap_win = 4'($urandom);
      rommap_ena = 2'($urandom);
      #1;
      bank = int'(za) / 16384;
      acc = (zmreq_n == 0) &&
            (zwr_n == 0 || (zrd_n == 0 && zcsrom_n == 0));
      ecs = 2'b11;
      eblk = 1'b0;
      for (int w = 0; w < 2; w++) begin
        if (rommap_ena[w] &&
            int'((rommap_win >> (2 * w)) & 4'h3) == bank) begin
          eblk = 1'b1;
          if (acc) ecs[w] = 1'b0;
        end
      end
      chk("rnd_cs", 32'(mem_cs_n), 32'(ecs));
      chk("rnd_blk", 32'(zblkrom), 32'(eblk));
      @(negedge fclk);
    end
    zmreq_n = 1'b1;
    zrd_n = 1'b1;
    zwr_n = 1'b1;
    zcsrom_n = 1'b1;
    repeat (3) @(negedge fclk);

    io_cyc(1, 0, 1, 16'h82AB, 8'h5A, 10);
    chk("wr_cnt", 32'(wr_cnt), 1);
    chk("wr_at", 32'(wr_at), 32'(t0 + 3));
    chk("wr_addr", 32'(ports_addr), 2);
    chk("wr_data", 32'(ports_wrdata), 32'h5A);
    chk("wr_nord", 32'(rd_cnt), 0);
    chk("wr_ge", 32'(ge_end), 1);

    ports_rddata = 32'hC3_22_11_44;
    io_cyc(0, 1, 0, 16'h83AB, 8'h00, 6);
    chk("rd_early", 32'(zd_early), 32'hFF);
    chk("rd_zd", 32'(zd_end), 32'hC3);
    chk("rd_rel", 32'(zd_rel), 32'hFF);
    chk("rd_cnt", 32'(rd_cnt), 1);
    chk("rd_at", 32'(rd_at), 32'(t1 + 3));
    chk("rd_addr", 32'(ports_addr), 3);
    chk("rd_nowr", 32'(wr_cnt), 0);

    io_cyc(0, 1, 0, 16'h02AB, 8'h00, 6);
    chk("m15_zd", 32'(zd_end), 32'hFF);
    chk("m15_ge", 32'(ge_end), 0);
    chk("m15_rd", 32'(rd_cnt), 0);
    io_cyc(1, 0, 1, 16'h82AC, 8'h77, 6);
    chk("mlo_ge", 32'(ge_end), 0);
    chk("mlo_wr", 32'(wr_cnt), 0);
    chk("mlo_data", 32'(ports_wrdata), 32'h5A);

    io_cyc(1, 1, 0, 16'h81AB, 8'h00, 8);
    chk("both_wr", 32'(wr_cnt), 1);
    chk("both_rd", 32'(rd_cnt), 0);
    chk("both_zd", 32'(zd_end), 32'hFF);
    chk("both_data", 32'(ports_wrdata), 32'hFF);
    chk("both_addr", 32'(ports_addr), 1);

    rd_cnt = 0;
    wr_cnt = 0;
    @(negedge fclk);
    za = 16'h81AB;
    ziorq_n = 1'b0;
    zrd_n = 1'b0;
    repeat (4) @(negedge fclk);
    chk("rr_zd", 32'(zd), 32'h11);
    rst = 1'b1;
    @(negedge fclk);
    chk("rr_rel", 32'(zd), 32'hFF);
    chk("rr_addr", 32'(ports_addr), 0);
    chk("rr_data", 32'(ports_wrdata), 0);
    chk("rr_rdstb", 32'(ports_rdstb), 0);
    rst = 1'b0;
    ziorq_n = 1'b1;
    zrd_n = 1'b1;
    repeat (6) @(negedge fclk);
    chk("rr_nord", 32'(rd_cnt), 0);
    chk("rr_nowr", 32'(wr_cnt), 0);
    io_cyc(0, 1, 0, 16'h82AB, 8'h00, 5);
    chk("rr_next_zd", 32'(zd_end), 32'h22);
    chk("rr_next_rd", 32'(rd_cnt), 1);

    m_addr = ports_addr;
    m_wrdata = ports_wrdata;
    for (int i = 0; i < 40; i++) begin
      int idx;
      int kind;
      bit w;
      logic [15:0] a;
      logic [7:0] d;
      logic [7:0] lo;
      bit h;
      logic [7:0] ezd;
      idx = $urandom_range(0, 3);
      kind = $urandom_range(0, 3);
      w = 1'($urandom);
      d = 8'($urandom);
      ports_rddata = $urandom;
      lo = 8'hAB;
      if (kind == 3) lo = 8'hAB ^ (8'h1 << $urandom_range(0, 7));
      a = {1'b1, 5'($urandom), 2'(idx), lo};
      if (kind == 2) a[15] = 1'b0;
      h = (kind < 2);
      io_cyc(w, !w, w, a, d, $urandom_range(4, 8));
      if (h) m_addr = 2'(idx);
      if (h && w) m_wrdata = d;
      if (w) ezd = d;
      else if (h) ezd = 8'((ports_rddata >> (8 * idx)) & 32'hFF);
      else ezd = 8'hFF;
      chk("r_wr", 32'(wr_cnt), 32'(h && w));
      chk("r_rd", 32'(rd_cnt), 32'(h && !w));
      chk("r_zd", 32'(zd_end), 32'(ezd));
      chk("r_rel", 32'(zd_rel), w ? 32'(d) : 32'hFF);
      chk("r_ge", 32'(ge_end), 32'(h));
      chk("r_addr", 32'(ports_addr), 32'(m_addr));
      chk("r_data", 32'(ports_wrdata), 32'(m_wrdata));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
